design1_wrapper: RTL and testbench

Control/status block for the audio-spectrum datapath. It exposes four DMA-style channel register banks over an AXI4-Lite slave: I2S S2MM, FFT TX MM2S, FFT RX S2MM and VGA MM2S. It tracks ping/pong buffer selection per channel and raises per-channel completion interrupts. It sits between the PS general-purpose master port and the stream movers, which report completion through xfer_done.

---
 rtl/design1_wrapper.sv | 191 +++++++++++++++++++
 tb/tb_design1_wrapper.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/design1_wrapper.sv
// design1_wrapper: AXI4-Lite control/status block for the audio-spectrum datapath.
// Four DMA-style register banks (ch0 I2S S2MM, ch1 FFT TX MM2S, ch2 FFT RX S2MM, ch3 VGA MM2S)
// with ping/pong buffer tracking and per-channel completion interrupts.
//
// Ports:
//   ps_clk, ps_rst            clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*           AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*              AXI4-Lite read address and data channels
//   xfer_done[3:0]            one-cycle completion pulse per channel from the stream movers
//   buf_sel[3:0]              active buffer per channel (0 ping, 1 pong)
//   irq[3:0]                  per-channel level interrupt (IOC_Irq & IOC_IrqEn)
module design1_wrapper #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  ps_clk,
    input  logic                  ps_rst,
    input  logic [31:0]           s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [31:0]           s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [3:0]            xfer_done,
    output logic [3:0]            buf_sel,
    output logic [3:0]            irq
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {StHalted, StIdle, StBusy} ch_state_e;

    ch_state_e             st_q   [4];
    logic [3:0]            ien_q;
    logic [3:0]            ioc_q;
    logic [3:0]            bsel_q;
    logic [DATA_WIDTH-1:0] tail_q [4];

    logic                  awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic       wr_fire, wr_win, rd_fire, rd_win;
    logic [1:0] wr_ch, rd_ch;
    logic [3:0] cr_we, sr_we, td_we, done_hit;

    // Only offset bits [7:6] and [4:0] select a register; bit 5 is ignored so each bank
    // answers at both the MM2S (0x00) and S2MM (0x20) layouts.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[13:8], s_axi_awaddr[5],
                                s_axi_araddr[13:8], s_axi_araddr[5]};

    function automatic logic [31:0] buf_addr(input logic [1:0] ch, input logic pong);
        logic [31:0] base;
        case (ch)
            2'd0:    base = 32'hC000_0000;
            2'd1:    base = 32'h8000_0000;
            2'd2:    base = 32'hC000_8000;
            default: base = 32'h8000_8000;
        endcase
        return base | {17'b0, pong, 14'b0};
    endfunction

    assign wr_fire = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign wr_win  = (s_axi_awaddr[31:16] == BASE_ADDR[31:16]);
    assign wr_ch   = s_axi_awaddr[15:14];
    assign rd_fire = arready_q & s_axi_arvalid;
    assign rd_win  = (s_axi_araddr[31:16] == BASE_ADDR[31:16]);
    assign rd_ch   = s_axi_araddr[15:14];

    always_comb begin
        cr_we    = '0;
        sr_we    = '0;
        td_we    = '0;
        done_hit = '0;
        for (int i = 0; i < 4; i++) begin
            if (wr_fire && wr_win && wr_ch == 2'(i) && s_axi_awaddr[7:6] == 2'b00) begin
                cr_we[i] = (s_axi_awaddr[4:0] == 5'h00);
                sr_we[i] = (s_axi_awaddr[4:0] == 5'h04);
                td_we[i] = (s_axi_awaddr[4:0] == 5'h10);
            end
            // A halt written in the same cycle suppresses the completion entirely.
            done_hit[i] = xfer_done[i] && st_q[i] == StBusy && !(cr_we[i] && !s_axi_wdata[0]);
        end
    end

    // Channel state, control and status flags.
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]   <= StHalted;
                tail_q[i] <= '0;
            end
            ien_q  <= '0;
            ioc_q  <= '0;
            bsel_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cr_we[i]) ien_q[i] <= s_axi_wdata[12];
                if (td_we[i]) tail_q[i] <= s_axi_wdata;

                if (cr_we[i] && !s_axi_wdata[0]) begin
                    st_q[i] <= StHalted;
                end else if (cr_we[i] && st_q[i] == StHalted) begin
                    st_q[i] <= StIdle;
                end else if (done_hit[i]) begin
                    st_q[i]   <= StIdle;
                    bsel_q[i] <= ~bsel_q[i];
                end else if (td_we[i] && st_q[i] == StIdle) begin
                    st_q[i] <= StBusy;
                end

                // Set beats a simultaneous write-1-to-clear.
                if (done_hit[i]) begin
                    ioc_q[i] <= 1'b1;
                end else if (sr_we[i] && s_axi_wdata[12]) begin
                    ioc_q[i] <= 1'b0;
                end
            end
        end
    end

    // Read data mux; Idle only reads 1 while running.
    always_comb begin
        rdata_d = '0;
        rresp_d = rd_win ? RespOkay : RespSlverr;
        if (rd_win && s_axi_araddr[7:6] == 2'b00) begin
            case (s_axi_araddr[4:0])
                5'h00: rdata_d = {19'b0, ien_q[rd_ch], 11'b0, st_q[rd_ch] != StHalted};
                5'h04: rdata_d = {19'b0, ioc_q[rd_ch], 10'b0, st_q[rd_ch] == StIdle,
                                  st_q[rd_ch] == StHalted};
                5'h08: rdata_d = buf_addr(rd_ch, bsel_q[rd_ch]);
                5'h10: rdata_d = tail_q[rd_ch];
                default: rdata_d = '0;
            endcase
        end
    end

    // AXI handshakes: ready pulses for one cycle, response held until accepted.
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
        end else begin
            awready_q <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_win ? RespOkay : RespSlverr;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= s_axi_arvalid & ~rvalid_q & ~arready_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign buf_sel       = bsel_q;
    assign irq           = ioc_q & ien_q;

endmodule

// File: tb/tb_design1_wrapper.sv
// Scoreboard bench for design1_wrapper: tasks push expected AXI responses into queues and a
// negedge monitor pops and compares whenever a response handshake occurs.
module tb_design1_wrapper;

    logic        ps_clk = 1'b0;
    logic        ps_rst = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [3:0]  xfer_done = '0;
    logic [3:0]  buf_sel;
    logic [3:0]  irq;

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] exp_r[$];
    string       exp_rn[$];
    logic [1:0]  exp_b[$];
    string       exp_bn[$];

    always #5 ps_clk = ~ps_clk;

    design1_wrapper #(
        .BASE_ADDR (32'h4000_0000),
        .DATA_WIDTH(32)
    ) dut (
        .ps_clk       (ps_clk),
        .ps_rst       (ps_rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .xfer_done    (xfer_done),
        .buf_sel      (buf_sel),
        .irq          (irq)
    );

    // Monitor: compare every completed response handshake against the scoreboard.
    logic [33:0] mon_e;
    string       mon_n;
    always @(negedge ps_clk) begin
        if (!ps_rst) begin
            if (s_axi_rvalid && s_axi_rready) begin
                n_vec++;
                if (exp_r.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected got resp=%b data=%h want no response",
                             s_axi_rresp, s_axi_rdata);
                end else begin
                    mon_e = exp_r.pop_front();
                    mon_n = exp_rn.pop_front();
                    if ({s_axi_rresp, s_axi_rdata} !== mon_e) begin
                        n_err++;
                        $display("FAIL %s got resp=%b data=%h want resp=%b data=%h", mon_n,
                                 s_axi_rresp, s_axi_rdata, mon_e[33:32], mon_e[31:0]);
                    end
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                n_vec++;
                if (exp_b.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected got bresp=%b want no response", s_axi_bresp);
                end else begin
                    mon_n = exp_bn.pop_front();
                    mon_e = {32'b0, exp_b.pop_front()};
                    if (s_axi_bresp !== mon_e[1:0]) begin
                        n_err++;
                        $display("FAIL %s got bresp=%b want bresp=%b", mon_n, s_axi_bresp,
                                 mon_e[1:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic axi_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp, input logic [3:0] done_mask,
                             input bit wait_resp);
        bit ok;
        exp_b.push_back(resp);
        exp_bn.push_back(name);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ps_clk);
            if (s_axi_awready && s_axi_wready) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_aw_timeout got awready=0 want 1", name);
        end
        xfer_done = done_mask;  // lands on the handshake edge
        @(posedge ps_clk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        xfer_done     = '0;
        if (wait_resp) begin
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge ps_clk);
                if (s_axi_bvalid && s_axi_bready) ok = 1'b1;
            end
            if (!ok) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_b_timeout got bvalid=0 want 1", name);
            end
            @(posedge ps_clk);
            #1;
        end
    endtask

    task automatic axi_read(input string name, input logic [31:0] addr, input logic [1:0] resp,
                            input logic [31:0] data);
        bit ok;
        exp_r.push_back({resp, data});
        exp_rn.push_back(name);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ps_clk);
            if (s_axi_arready) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_ar_timeout got arready=0 want 1", name);
        end
        @(posedge ps_clk);
        #1;
        s_axi_arvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ps_clk);
            if (s_axi_rvalid && s_axi_rready) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_r_timeout got rvalid=0 want 1", name);
        end
        @(posedge ps_clk);
        #1;
    endtask

    task automatic pulse_done(input logic [3:0] mask);
        @(negedge ps_clk);
        xfer_done = mask;
        @(posedge ps_clk);
        #1;
        xfer_done = '0;
        @(negedge ps_clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge ps_clk);
        check("rst_awready", {31'b0, s_axi_awready}, 32'd0);
        check("rst_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, s_axi_rvalid}, 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_irq_bufsel", {24'b0, irq, buf_sel}, 32'd0);
        ps_rst = 1'b0;
        repeat (2) @(negedge ps_clk);

        // Reset register values
        axi_read("rst_i2s_dmasr", 32'h4000_0004, 2'b00, 32'h0000_0001);
        axi_read("rst_i2s_curr", 32'h4000_0008, 2'b00, 32'hC000_0000);
        axi_read("rst_i2s_dmasr_s2mm", 32'h4000_0024, 2'b00, 32'h0000_0001);
        axi_read("rst_vga_curr", 32'h4000_C008, 2'b00, 32'h8000_8000);

        // FFT_TX run, descriptor, completion
        axi_write("fft_tx_cr", 32'h4000_4000, 32'h0000_1001, 2'b00, 4'h0, 1);
        axi_read("fft_tx_cr_rd", 32'h4000_4000, 2'b00, 32'h0000_1001);
        axi_read("fft_tx_idle", 32'h4000_4004, 2'b00, 32'h0000_0002);
        axi_write("fft_tx_td", 32'h4000_4010, 32'h8000_0000, 2'b00, 4'h0, 1);
        axi_read("fft_tx_busy", 32'h4000_4004, 2'b00, 32'h0000_0000);
        axi_read("fft_tx_td_rd", 32'h4000_4010, 2'b00, 32'h8000_0000);
        pulse_done(4'b0010);
        check("done1_irq", {28'b0, irq}, 32'h2);
        check("done1_bufsel", {28'b0, buf_sel}, 32'h2);
        axi_read("done1_dmasr", 32'h4000_4004, 2'b00, 32'h0000_1002);
        axi_read("done1_curr", 32'h4000_4008, 2'b00, 32'h8000_4000);

        // W1C, then a second completion back to ping
        axi_write("fft_tx_w1c", 32'h4000_4004, 32'h0000_1000, 2'b00, 4'h0, 1);
        check("w1c_irq", {28'b0, irq}, 32'h0);
        axi_read("w1c_dmasr", 32'h4000_4004, 2'b00, 32'h0000_0002);
        axi_write("fft_tx_td2", 32'h4000_4010, 32'h8000_4000, 2'b00, 4'h0, 1);
        pulse_done(4'b0010);
        check("done2_irq", {28'b0, irq}, 32'h2);
        check("done2_bufsel", {28'b0, buf_sel}, 32'h0);
        axi_read("done2_curr", 32'h4000_4008, 2'b00, 32'h8000_0000);
        axi_write("fft_tx_w1c2", 32'h4000_4004, 32'h0000_1000, 2'b00, 4'h0, 1);

        // FFT_RX S2MM with IrqEn clear
        axi_write("fft_rx_cr", 32'h4000_8020, 32'h0000_0001, 2'b00, 4'h0, 1);
        axi_write("fft_rx_td", 32'h4000_8030, 32'hC000_8000, 2'b00, 4'h0, 1);
        pulse_done(4'b0100);
        axi_read("fft_rx_dmasr", 32'h4000_8024, 2'b00, 32'h0000_1002);
        axi_read("fft_rx_curr", 32'h4000_8028, 2'b00, 32'hC000_C000);
        check("fft_rx_irq", {28'b0, irq}, 32'h0);
        check("fft_rx_bufsel", {28'b0, buf_sel}, 32'h4);

        // Completion while halted is ignored
        pulse_done(4'b0001);
        check("halted_done_bufsel", {28'b0, buf_sel}, 32'h4);
        axi_read("halted_done_dmasr", 32'h4000_0004, 2'b00, 32'h0000_0001);

        // Out-of-window and unmapped offsets
        axi_read("oow_rd", 32'h5000_0000, 2'b10, 32'h0000_0000);
        axi_write("oow_wr", 32'h4001_0000, 32'h0000_1001, 2'b10, 4'h0, 1);
        axi_read("oow_wr_noeffect", 32'h4000_0000, 2'b00, 32'h0000_0000);
        axi_write("unmapped_wr", 32'h4000_400C, 32'hFFFF_FFFF, 2'b00, 4'h0, 1);
        axi_read("unmapped_rd", 32'h4000_400C, 2'b00, 32'h0000_0000);
        axi_read("msb_rd", 32'h4000_4014, 2'b00, 32'h0000_0000);

        // W1C and completion on the same edge: set wins
        axi_write("sw_td", 32'h4000_4010, 32'h1111_0000, 2'b00, 4'h0, 1);
        axi_write("sw_w1c_done", 32'h4000_4004, 32'h0000_1000, 2'b00, 4'b0010, 1);
        check("setwins_irq", {28'b0, irq}, 32'h2);
        check("setwins_bufsel", {28'b0, buf_sel}, 32'h6);
        axi_read("setwins_dmasr", 32'h4000_4004, 2'b00, 32'h0000_1002);

        // Halt and completion on the same edge: halt wins
        axi_write("hw_w1c", 32'h4000_4004, 32'h0000_1000, 2'b00, 4'h0, 1);
        axi_write("hw_td", 32'h4000_4010, 32'h2222_0000, 2'b00, 4'h0, 1);
        axi_write("hw_halt_done", 32'h4000_4000, 32'h0000_1000, 2'b00, 4'b0010, 1);
        check("haltwins_irq", {28'b0, irq}, 32'h0);
        check("haltwins_bufsel", {28'b0, buf_sel}, 32'h6);
        axi_read("haltwins_dmasr", 32'h4000_4004, 2'b00, 32'h0000_0001);
        axi_read("haltwins_cr", 32'h4000_4000, 2'b00, 32'h0000_1000);
        axi_read("haltwins_td", 32'h4000_4010, 2'b00, 32'h2222_0000);

        // Build up live state, then hold bready low and reset mid-transfer
        axi_write("pre_cr", 32'h4000_4000, 32'h0000_1001, 2'b00, 4'h0, 1);
        axi_write("pre_td", 32'h4000_4010, 32'h3333_0000, 2'b00, 4'h0, 1);
        pulse_done(4'b0010);
        check("pre_irq", {28'b0, irq}, 32'h2);
        check("pre_bufsel", {28'b0, buf_sel}, 32'h4);
        s_axi_bready = 1'b0;
        axi_write("hold_td", 32'h4000_4010, 32'h4444_0000, 2'b00, 4'h0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge ps_clk);
            check("hold_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
        end
        s_axi_awaddr  = 32'h4000_4010;
        s_axi_wdata   = 32'h5555_0000;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ps_clk);
            check("hold_awready", {31'b0, s_axi_awready}, 32'd0);
        end
        #2;
        ps_rst = 1'b1;
        #1;
        check("midrst_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
        check("midrst_irq_bufsel", {24'b0, irq, buf_sel}, 32'd0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        exp_b.delete();
        exp_bn.delete();
        repeat (2) @(negedge ps_clk);
        ps_rst       = 1'b0;
        s_axi_bready = 1'b1;
        @(negedge ps_clk);
        axi_read("post_rst_dmasr", 32'h4000_4004, 2'b00, 32'h0000_0001);
        axi_read("post_rst_td", 32'h4000_4010, 2'b00, 32'h0000_0000);
        axi_read("post_rst_rx_dmasr", 32'h4000_8024, 2'b00, 32'h0000_0001);
        check("post_rst_irq", {28'b0, irq}, 32'h0);

        repeat (3) @(negedge ps_clk);
        check("sb_rd_drained", exp_r.size(), 32'd0);
        check("sb_wr_drained", exp_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
